// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: pipelined SRAM-like fetch with credit-based flow control,
// an in-order PC queue and a DEPTH-entry instruction FIFO toward decode.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module if_prefetch_stage #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ds_valid,
  input  logic        ds_ready,
  output logic [31:0] ds_pc,
  output logic [31:0] ds_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_discard_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic        req_q, req_n;
  logic [31:0] fetch_pc_q, fetch_pc_n;
  logic        redir_pend_q, redir_pend_n;
  logic [31:0] redir_pc_q, redir_pc_n;
  cnt_t        pending_q, pending_n;
  cnt_t        discard_q, discard_n;
  cnt_t        count_q, count_n;
  ptr_t        pcq_wr_q, pcq_rd_q, fifo_wr_q, fifo_rd_q;

  logic [31:0] pc_queue  [DEPTH];
  logic [31:0] fifo_pc   [DEPTH];
  logic [31:0] fifo_inst [DEPTH];

  logic        accept, ret, drop, push, pop, hold;
  logic [31:0] target;

  assign accept = req_q & inst_sram_addr_ok;
  // A data_ok with nothing pending is a stale beat from before reset.
  assign ret    = inst_sram_data_ok & (pending_q != '0);
  assign drop   = ret & (discard_q != '0);
  assign push   = ret & (discard_q == '0) & ~redirect_valid;
  assign pop    = ds_valid & ds_ready & ~redirect_valid;
  assign hold   = req_q & ~inst_sram_addr_ok;
  assign target = {redirect_pc[31:2], 2'b00};

  // NOTE: every variable assigned here gets a value on every path first, so no latch is inferred.
  always_comb begin
    pending_n    = pending_q + cnt_t'(accept) - cnt_t'(ret);
    count_n      = redirect_valid ? '0 : count_q + cnt_t'(push) - cnt_t'(pop);
    discard_n    = redirect_valid ? pending_n
                                  : discard_q - cnt_t'(drop) + cnt_t'(accept & redir_pend_q);
    // Raise req only if every outstanding response still has a guaranteed slot.
    req_n        = hold | (({1'b0, pending_n} + {1'b0, count_n}) < DEPTH_W);
    fetch_pc_n   = fetch_pc_q;
    redir_pend_n = redir_pend_q;
    redir_pc_n   = redir_pc_q;
    if (redirect_valid && hold) begin
      // The presented request must complete with its old address; remember the target.
      redir_pend_n = 1'b1;
      redir_pc_n   = target;
    end else if (redirect_valid) begin
      fetch_pc_n   = target;
      redir_pend_n = 1'b0;
    end else if (accept && redir_pend_q) begin
      fetch_pc_n   = redir_pc_q;
      redir_pend_n = 1'b0;
    end else if (accept) begin
      fetch_pc_n   = fetch_pc_q + 32'd4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q        <= 1'b0;
      fetch_pc_q   <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
      pending_q    <= '0;
      discard_q    <= '0;
      count_q      <= '0;
      pcq_wr_q     <= '0;
      pcq_rd_q     <= '0;
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
    end else begin
      req_q        <= req_n;
      fetch_pc_q   <= fetch_pc_n;
      redir_pend_q <= redir_pend_n;
      redir_pc_q   <= redir_pc_n;
      pending_q    <= pending_n;
      discard_q    <= discard_n;
      count_q      <= count_n;
      if (accept) pcq_wr_q <= pcq_wr_q + ptr_t'(1);
      if (ret)    pcq_rd_q <= pcq_rd_q + ptr_t'(1);
      if (redirect_valid) begin
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
      end else begin
        if (push) fifo_wr_q <= fifo_wr_q + ptr_t'(1);
        if (pop)  fifo_rd_q <= fifo_rd_q + ptr_t'(1);
      end
    end
  end

  // NOTE: storage arrays are not reset; pointers and counts alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (accept) pc_queue[pcq_wr_q] <= fetch_pc_q;
    if (push) begin
      fifo_pc[fifo_wr_q]   <= pc_queue[pcq_rd_q];
      fifo_inst[fifo_wr_q] <= inst_sram_rdata;
    end
  end

  assign inst_sram_req  = req_q;
  assign inst_sram_addr = fetch_pc_q;
  assign ds_valid       = (count_q != '0);
  assign ds_pc          = ds_valid ? fifo_pc[fifo_rd_q]   : '0;
  assign ds_inst        = ds_valid ? fifo_inst[fifo_rd_q] : '0;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt   <= '0;
      perf_discard_cnt <= '0;
    end else begin
      if (ds_valid && ds_ready) perf_fetch_cnt   <= perf_fetch_cnt + 32'd1;
      if (drop)                 perf_discard_cnt <= perf_discard_cnt + 32'd1;
    end
  end
`endif

endmodule
